// File: rtl/ram_input_pkg.sv
// Shared types for the input-sample RAM playback engine.
// Latency: n/a (types only).
// Backpressure: n/a.
package ram_input_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with registered storage and a flush input.
// Latency: 1 cycle from push to pop_vld; head data is held stable until popped.
// Backpressure: pushes while full are dropped, so the producer must track count.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop_vld = (count != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push_vld && (count != CW'(DEPTH));
    assign do_pop  = pop_rdy && pop_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ram_sdp_1r1w.sv
// Simple dual-port sample RAM, one write port and one registered read port.
// Latency: 1 cycle read; a same-address write in the read cycle returns the new data.
// Backpressure: none, both ports accept every cycle.
module ram_sdp_1r1w #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/ram_input_streamer.sv
// Sample RAM with a playback engine streaming [base, base+len) on valid/ready, once or looped.
// Latency: start in cycle N gives the first out_valid in N+2, then 1 sample/cycle.
// Backpressure: out_ready low holds the head sample; reads stop while the 2-entry skid is committed.
module ram_input_streamer
    import ram_input_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  loop_en,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(2 ** ADDR_WIDTH);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, rd_ptr_q;
    logic [LW-1:0]         len_q, rem_q;
    logic                  loop_q;
    logic                  infl_q, infl_last_q;
    logic                  zero_done_q;

    logic                  idle, start_go, issue, issue_last, pop, drain_done;
    logic [LW-1:0]         len_c, cur_len, cur_rem;
    logic [ADDR_WIDTH-1:0] cur_base, rd_addr;
    logic                  cur_loop;
    logic [2:0]            occ_eff;
    logic [1:0]            fifo_cnt;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [DATA_WIDTH:0]   head_dat;

    // In IDLE the first read is issued straight from the start inputs, saving a cycle of latency.
    always_comb begin
        len_c      = (length > LEN_MAX) ? LEN_MAX : length;
        idle       = (state_q == IDLE);
        start_go   = idle && start && !abort && (len_c != '0);
        cur_base   = idle ? base_addr : base_q;
        cur_len    = idle ? len_c : len_q;
        cur_rem    = idle ? len_c : rem_q;
        cur_loop   = idle ? loop_en : loop_q;
        rd_addr    = idle ? base_addr : rd_ptr_q;
        issue_last = (cur_rem == LEN_ONE);
        pop        = out_valid && out_ready;
        occ_eff    = 3'(fifo_cnt) + 3'(infl_q) - 3'(pop);
        issue      = 1'b0;
        if (idle) begin
            issue = start_go;
        end else if ((state_q == RUN) && !abort) begin
            issue = (occ_eff < 3'd2);
        end
        drain_done = (state_q == DRAIN) && pop && out_last && !abort;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_go) state_d = (issue_last && !cur_loop) ? DRAIN : RUN;
                RUN:     if (issue && issue_last && !cur_loop) state_d = DRAIN;
                DRAIN:   if (drain_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            if (start_go) begin
                base_q <= base_addr;
                len_q  <= len_c;
                loop_q <= loop_en;
            end
            // Reloading on the last read keeps loop passes back to back.
            if (issue) begin
                if (issue_last) begin
                    rd_ptr_q <= cur_base;
                    rem_q    <= cur_len;
                end else begin
                    rd_ptr_q <= rd_addr + ADDR_WIDTH'(1);
                    rem_q    <= cur_rem - LEN_ONE;
                end
            end
            infl_q      <= issue;
            infl_last_q <= issue_last;
            zero_done_q <= idle && start && !abort && (len_c == '0);
        end
    end

    ram_sdp_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (rd_dat)
    );

    // Abort flushes the skid; the read landing in the same cycle is dropped by the flush.
    fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (2)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push_vld (infl_q),
        .push_dat ({infl_last_q, rd_dat}),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat),
        .count    (fifo_cnt)
    );

    assign {out_last, out_data} = head_dat;
    assign busy = (state_q != IDLE);
    assign done = zero_done_q || drain_done;

endmodule

// File: tb/tb_ram_input_streamer.sv
// Scoreboard bench for ram_input_streamer at ADDR_WIDTH=4 (16-entry window wrap).
module tb_ram_input_streamer;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          loop_en = 1'b0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } samp_t;

    samp_t         exp_q[$];
    samp_t         mon_e;
    samp_t         stall_s;
    logic          stall_q = 1'b0;
    logic [DW-1:0] model [DEPTH];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    ram_input_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .loop_en   (loop_en),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Output monitor: every accepted sample is popped from the scoreboard; stalled heads must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_vec++;
                if (!out_valid || ({out_last, out_data} !== stall_s)) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b last=%b data=%h, need v=1 last=%b data=%h",
                             out_valid, out_last, out_data, stall_s.last, stall_s.dat);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_sample: got last=%b data=%h, nothing expected", out_last, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_last, out_data} !== mon_e) begin
                        n_err++;
                        $display("FAIL sample: got last=%b data=%h, need last=%b data=%h",
                                 out_last, out_data, mon_e.last, mon_e.dat);
                    end
                end
            end
            stall_q = out_valid && !out_ready && !abort;
            stall_s = {out_last, out_data};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        tick();
        wr_en   = 1'b0;
        model[a % DEPTH] = DW'(d);
    endtask

    task automatic push_window(input int base, input int len, input int passes);
        samp_t s;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                s.dat  = model[(base + i) % DEPTH];
                s.last = (i == len - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic fire(input int base, input int len, input bit lp);
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        loop_en   = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int dones, output bit timed_out);
        dones = 0;
        timed_out = 1'b1;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
            if (!busy && !out_valid && exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int dones;
        bit to;
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_last, busy, done, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b l=%b b=%b d=%b data=%h, need all 0",
                     out_valid, out_last, busy, done, out_data);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) host_wr(i, i);
        out_ready = 1'b1;
        push_window(0, 8, 1);
        fire(0, 8, 1'b0);
        tick();
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_midrun_busy: got busy=%b, need 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, out_last, busy, done, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_midrun_outputs: got v=%b l=%b b=%b d=%b data=%h, need all 0",
                     out_valid, out_last, busy, done, out_data);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_window(0, 4, 1);
        fire(0, 4, 1'b0);
        wait_idle(40, dones, to);
        n_vec++;
        if (to || dones != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_restart: got timeout=%b dones=%0d left=%0d, need 0/1/0", to, dones, exp_q.size());
        end
    endtask

    task automatic test_one_shot();
        logic [2:0] got, need;
        push_window(5, 3, 1);
        base_addr = 4'd5;
        length    = 5'd3;
        loop_en   = 1'b0;
        start     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got  = {out_valid, done, busy};
            need = {(c >= 2 && c <= 4), (c == 4), (c >= 1 && c <= 4)};
            n_vec++;
            if (got !== need) begin
                n_err++;
                $display("FAIL one_shot_cycle%0d: got v/done/busy=%b, need %b", c, got, need);
            end
            tick();
            start = 1'b0;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL one_shot_drain: got %0d samples left, need 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int  dones = 0;
        bit  to = 1'b1;
        push_window(2, 8, 1);
        base_addr = 4'd2;
        length    = 5'd8;
        loop_en   = 1'b0;
        start     = 1'b1;
        for (int k = 0; k < 60; k++) begin
            out_ready = (k < 10) ? (k % 2 == 0) : (k >= 15);
            @(negedge clk);
            #1;
            if (done) dones++;
            if (k > 0 && !busy && !out_valid && exp_q.size() == 0) begin
                to = 1'b0;
                break;
            end
            tick();
            start = 1'b0;
        end
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (to || dones != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL backpressure: got timeout=%b dones=%0d left=%0d, need 0/1/0", to, dones, exp_q.size());
        end
    endtask

    task automatic test_wrap_loop();
        logic [2:0] got, need;
        push_window(14, 4, 3);
        base_addr = 4'd14;
        length    = 5'd4;
        loop_en   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            start     = (k == 0);
            abort     = (k == 14);
            out_ready = (k != 14);
            @(negedge clk);
            got  = {out_valid, busy, done};
            need = {(k >= 2 && k <= 14), (k >= 1 && k <= 14), 1'b0};
            n_vec++;
            if (got !== need) begin
                n_err++;
                $display("FAIL wrap_loop_cycle%0d: got v/busy/done=%b, need %b", k, got, need);
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        loop_en = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_loop_count: got %0d samples left, need 0", exp_q.size());
        end
    endtask

    task automatic test_clamp();
        int dones;
        bit to;
        push_window(3, 16, 1);
        fire(3, 20, 1'b0);
        wait_idle(60, dones, to);
        n_vec++;
        if (to || dones != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL clamp: got timeout=%b dones=%0d left=%0d, need 0/1/0", to, dones, exp_q.size());
        end
    endtask

    task automatic test_collisions();
        int         dones;
        bit         to;
        bit         bad;
        logic [2:0] dseq;
        samp_t      s;
        bad = 1'b0;
        base_addr = 4'd0;
        length    = 5'd4;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || out_valid || done) bad = 1'b1;
            tick();
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL start_abort: got activity after start+abort, need idle");
        end

        push_window(0, 3, 1);
        fire(0, 3, 1'b0);
        fire(10, 5, 1'b0);
        wait_idle(40, dones, to);
        n_vec++;
        if (to || dones != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL start_busy: got timeout=%b dones=%0d left=%0d, need 0/1/0", to, dones, exp_q.size());
        end

        bad = 1'b0;
        dseq = '0;
        length = 5'd0;
        start  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dseq = {dseq[1:0], done};
            if (busy || out_valid) bad = 1'b1;
            tick();
            start = 1'b0;
        end
        n_vec++;
        if (bad || dseq !== 3'b010) begin
            n_err++;
            $display("FAIL zero_len: got done seq=%b activity=%b, need 010/0", dseq, bad);
        end

        s.dat = 16'd5;     s.last = 1'b0; exp_q.push_back(s);
        s.dat = 16'hBEEF;  s.last = 1'b0; exp_q.push_back(s);
        s.dat = 16'd7;     s.last = 1'b1; exp_q.push_back(s);
        fire(5, 3, 1'b0);
        host_wr(6, 16'hBEEF);
        wait_idle(40, dones, to);
        n_vec++;
        if (to || dones != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL write_first: got timeout=%b dones=%0d left=%0d, need 0/1/0", to, dones, exp_q.size());
        end
        host_wr(6, 6);
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_backpressure();
        test_wrap_loop();
        test_clamp();
        test_collisions();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
